// File: rtl/imu_filter_sequencer.sv
// IMU acceleration-path sequencer: paces sample reads, drives the reader/filter handshakes,
// tracks filter warm-up and presents filtered samples downstream with timeout/retry/fault handling.
module imu_filter_sequencer #(
    parameter int unsigned FILTER_LENGTH  = 200,
    parameter int unsigned TICK_DIV       = 250000,
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Enable,
    input  logic       ReadDone,
    input  logic       FilterDataReady,
    input  logic       OutAck,
    input  logic       FaultClear,
    output logic       ReadReq,
    output logic       FilterStrobe,
    output logic       OutValid,
    output logic       Warm,
    output logic       Fault,
    output logic [7:0] OverrunCount,
    output logic [2:0] State
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned OW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned SW = $clog2(FILTER_LENGTH + 1);
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_DIV - 1);
    localparam logic [OW-1:0] TMO_LAST     = OW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] SAMPLES_FULL = SW'(FILTER_LENGTH);
    localparam logic [SW-1:0] SAMPLES_LAST = SW'(FILTER_LENGTH - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_TICK   = 3'd1,
        S_REQUEST     = 3'd2,
        S_RETRY_GAP   = 3'd3,
        S_SHIFT       = 3'd4,
        S_WAIT_FILTER = 3'd5,
        S_PRESENT     = 3'd6
    } state_e;

    state_e        state_q;
    logic [TW-1:0] tick_cnt_q;
    logic          tick;
    logic [OW-1:0] tmo_q;
    logic [RW-1:0] retry_q;
    logic [RW-1:0] retry_d;
    logic [SW-1:0] samples_q;
    logic          rreq_q;
    logic          strobe_q;
    logic          oval_q;
    logic          warm_q;
    logic          fault_q;
    logic [7:0]    ovr_q;

    assign tick    = Enable && (tick_cnt_q == TICK_LAST);
    assign retry_d = retry_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (!Enable || tick_cnt_q == TICK_LAST) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    // Ticks are never queued: one arriving outside WAIT_TICK only bumps the overrun count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= '0;
        end else if (tick && state_q != S_WAIT_TICK && ovr_q != 8'hFF) begin
            ovr_q <= ovr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tmo_q     <= '0;
            retry_q   <= '0;
            samples_q <= '0;
            rreq_q    <= 1'b0;
            strobe_q  <= 1'b0;
            oval_q    <= 1'b0;
            warm_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            // A fault set later in this block overrides the clear in the same cycle.
            if (FaultClear) fault_q <= 1'b0;
            if (!Enable) begin
                state_q   <= S_IDLE;
                tmo_q     <= '0;
                retry_q   <= '0;
                samples_q <= '0;
                rreq_q    <= 1'b0;
                strobe_q  <= 1'b0;
                oval_q    <= 1'b0;
                warm_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: state_q <= S_WAIT_TICK;
                    S_WAIT_TICK: begin
                        if (tick) begin
                            state_q <= S_REQUEST;
                            rreq_q  <= 1'b1;
                            retry_q <= '0;
                            tmo_q   <= '0;
                        end
                    end
                    S_REQUEST: begin
                        tmo_q <= tmo_q + 1'b1;
                        if (ReadDone) begin
                            state_q  <= S_SHIFT;
                            rreq_q   <= 1'b0;
                            strobe_q <= 1'b1;
                        end else if (tmo_q == TMO_LAST) begin
                            rreq_q  <= 1'b0;
                            retry_q <= retry_d;
                            if (retry_d < RETRY_MAX) begin
                                state_q <= S_RETRY_GAP;
                            end else begin
                                fault_q <= 1'b1;
                                state_q <= S_WAIT_TICK;
                            end
                        end
                    end
                    S_RETRY_GAP: begin
                        state_q <= S_REQUEST;
                        rreq_q  <= 1'b1;
                        tmo_q   <= '0;
                    end
                    S_SHIFT: begin
                        strobe_q <= 1'b0;
                        if (samples_q != SAMPLES_FULL) samples_q <= samples_q + 1'b1;
                        warm_q  <= (samples_q >= SAMPLES_LAST);
                        state_q <= S_WAIT_FILTER;
                    end
                    S_WAIT_FILTER: begin
                        if (FilterDataReady) begin
                            if (warm_q) begin
                                state_q <= S_PRESENT;
                                oval_q  <= 1'b1;
                            end else begin
                                state_q <= S_WAIT_TICK;
                            end
                        end
                    end
                    S_PRESENT: begin
                        if (OutAck) begin
                            oval_q  <= 1'b0;
                            state_q <= S_WAIT_TICK;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign ReadReq      = rreq_q;
    assign FilterStrobe = strobe_q;
    assign OutValid     = oval_q;
    assign Warm         = warm_q;
    assign Fault        = fault_q;
    assign OverrunCount = ovr_q;
    assign State        = state_q;

endmodule

// File: tb/tb_imu_filter_sequencer.sv
// Directed bench for imu_filter_sequencer: per-cycle vector table plus reactive warm-up and async reset.
module tb_imu_filter_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Enable, ReadDone, FilterDataReady, OutAck, FaultClear;
    logic       ReadReq, FilterStrobe, OutValid, Warm, Fault;
    logic [7:0] OverrunCount;
    logic [2:0] State;

    always #5 clk = ~clk;

    imu_filter_sequencer #(
        .FILTER_LENGTH (4),
        .TICK_DIV      (10),
        .TIMEOUT_CYCLES(8),
        .MAX_RETRY     (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Enable         (Enable),
        .ReadDone       (ReadDone),
        .FilterDataReady(FilterDataReady),
        .OutAck         (OutAck),
        .FaultClear     (FaultClear),
        .ReadReq        (ReadReq),
        .FilterStrobe   (FilterStrobe),
        .OutValid       (OutValid),
        .Warm           (Warm),
        .Fault          (Fault),
        .OverrunCount   (OverrunCount),
        .State          (State)
    );

    // inputs {Enable, ReadDone, FilterDataReady, OutAck, FaultClear}
    localparam logic [4:0] I_OFF = 5'b00000, I_EN = 5'b10000, I_RD = 5'b11000,
                           I_FDR = 5'b10100, I_ACK = 5'b10010, I_FCLR = 5'b10001;
    // outputs {ReadReq, FilterStrobe, OutValid, Warm, Fault}
    localparam logic [4:0] O_NONE = 5'b00000, O_REQ = 5'b10000, O_STB = 5'b01000,
                           O_OV = 5'b00100, O_W = 5'b00010, O_F = 5'b00001;

    typedef struct {
        int unsigned n;
        logic [4:0]  in;
        logic [2:0]  st;
        logic [4:0]  out;
        logic [7:0]  ovr;
    } vec_t;

    vec_t        vecs[$];
    int unsigned tests = 0;
    int unsigned fails = 0;

    function automatic void add(int unsigned n, logic [4:0] in, logic [2:0] st,
                                logic [4:0] out, logic [7:0] ovr);
        vec_t v;
        v.n = n; v.in = in; v.st = st; v.out = out; v.ovr = ovr;
        vecs.push_back(v);
    endfunction

    function automatic logic [15:0] snapshot();
        return {State, ReadReq, FilterStrobe, OutValid, Warm, Fault, OverrunCount};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_rreq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ReadReq) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_sample(input int unsigned idx, input bit last);
        bit ok;
        wait_rreq(ok);
        check($sformatf("req_seen%0d", idx), {15'd0, ok}, 16'd1);
        ReadDone = 1'b1;
        @(posedge clk); #1;
        ReadDone = 1'b0;
        check($sformatf("strobe%0d", idx), {12'd0, State, FilterStrobe}, {12'd0, 3'd4, 1'b1});
        @(posedge clk); #1;
        FilterDataReady = 1'b1;
        @(posedge clk); #1;
        FilterDataReady = 1'b0;
        check($sformatf("after_fdr%0d", idx), {12'd0, State, OutValid},
              last ? {12'd0, 3'd6, 1'b1} : {12'd0, 3'd1, 1'b0});
    endtask

    initial begin
        rst_n = 1'b0;
        {Enable, ReadDone, FilterDataReady, OutAck, FaultClear} = I_OFF;

        // Warm-up: three unwarm samples, ticks every 10 cycles starting at edge 10
        add(1, I_EN, 3'd1, O_NONE, 8'd0);
        add(8, I_EN, 3'd1, O_NONE, 8'd0);
        for (int s = 0; s < 3; s++) begin
            add(3, I_EN,  3'd2, O_REQ,  8'd0);
            add(1, I_RD,  3'd4, O_STB,  8'd0);
            add(1, I_EN,  3'd5, O_NONE, 8'd0);
            add(1, I_FDR, 3'd1, O_NONE, 8'd0);
            add(4, I_EN,  3'd1, O_NONE, 8'd0);
        end
        add(3, I_EN,  3'd2, O_REQ,       8'd0);
        add(1, I_RD,  3'd4, O_STB,       8'd0);
        add(1, I_EN,  3'd5, O_W,         8'd0);
        add(1, I_FDR, 3'd6, O_OV | O_W,  8'd0);
        // Handshake stall with an overrun tick
        add(4, I_EN,  3'd6, O_OV | O_W,  8'd0);
        add(1, I_EN,  3'd6, O_OV | O_W,  8'd1);
        add(1, I_ACK, 3'd1, O_W,         8'd1);
        // Timeout then retry success
        add(8, I_EN,  3'd1, O_W,         8'd1);
        add(8, I_EN,  3'd2, O_REQ | O_W, 8'd1);
        add(1, I_EN,  3'd3, O_W,         8'd1);
        add(1, I_EN,  3'd2, O_REQ | O_W, 8'd1);
        add(1, I_EN,  3'd2, O_REQ | O_W, 8'd2);
        add(1, I_RD,  3'd4, O_STB | O_W, 8'd2);
        add(1, I_EN,  3'd5, O_W,         8'd2);
        add(1, I_FDR, 3'd6, O_OV | O_W,  8'd2);
        add(1, I_ACK, 3'd1, O_W,         8'd2);
        // Two timeouts -> Fault, sequencing continues, FaultClear
        add(5, I_EN,   3'd1, O_W,               8'd2);
        add(8, I_EN,   3'd2, O_REQ | O_W,       8'd2);
        add(1, I_EN,   3'd3, O_W,               8'd2);
        add(1, I_EN,   3'd2, O_REQ | O_W,       8'd2);
        add(7, I_EN,   3'd2, O_REQ | O_W,       8'd3);
        add(3, I_EN,   3'd1, O_W | O_F,         8'd3);
        add(1, I_EN,   3'd2, O_REQ | O_W | O_F, 8'd3);
        add(1, I_FCLR, 3'd2, O_REQ | O_W,       8'd3);
        add(1, I_RD,   3'd4, O_STB | O_W,       8'd3);
        add(1, I_EN,   3'd5, O_W,               8'd3);
        add(1, I_FDR,  3'd6, O_OV | O_W,        8'd3);
        add(1, I_ACK,  3'd1, O_W,               8'd3);
        // ReadDone on the expiry cycle wins
        add(4, I_EN,  3'd1, O_W,         8'd3);
        add(8, I_EN,  3'd2, O_REQ | O_W, 8'd3);
        add(1, I_RD,  3'd4, O_STB | O_W, 8'd3);
        add(1, I_EN,  3'd5, O_W,         8'd3);
        add(1, I_FDR, 3'd6, O_OV | O_W,  8'd4);
        add(1, I_ACK, 3'd1, O_W,         8'd4);
        // Enable dropped in REQUEST
        add(8, I_EN,  3'd1, O_W,         8'd4);
        add(2, I_EN,  3'd2, O_REQ | O_W, 8'd4);
        add(3, I_OFF, 3'd0, O_NONE,      8'd4);

        repeat (2) @(posedge clk);
        #1;
        check("reset", snapshot(), 16'h0000);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int unsigned k = 0; k < vecs[i].n; k++) begin
                {Enable, ReadDone, FilterDataReady, OutAck, FaultClear} = vecs[i].in;
                @(posedge clk); #1;
                check($sformatf("vec%0d_c%0d", i, k), snapshot(),
                      {vecs[i].st, vecs[i].out, vecs[i].ovr});
            end
        end

        // Re-warm after disable, then reset asynchronously while presenting
        {Enable, ReadDone, FilterDataReady, OutAck, FaultClear} = I_EN;
        for (int s = 0; s < 4; s++) do_sample(s, s == 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", snapshot(), 16'h0000);
        @(posedge clk); #1;
        check("held_reset", snapshot(), 16'h0000);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
